// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg: shared M-extension op codes, FSM states and helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ex_muldiv_pkg;

  localparam logic [3:0] MD_OP_MUL    = 4'd0;
  localparam logic [3:0] MD_OP_MULH   = 4'd1;
  localparam logic [3:0] MD_OP_MULHSU = 4'd2;
  localparam logic [3:0] MD_OP_MULHU  = 4'd3;
  localparam logic [3:0] MD_OP_DIV    = 4'd4;
  localparam logic [3:0] MD_OP_DIVU   = 4'd5;
  localparam logic [3:0] MD_OP_REM    = 4'd6;
  localparam logic [3:0] MD_OP_REMU   = 4'd7;
  localparam logic [3:0] MD_OP_MULW   = 4'd8;
  localparam logic [3:0] MD_OP_DIVW   = 4'd9;
  localparam logic [3:0] MD_OP_DIVUW  = 4'd10;
  localparam logic [3:0] MD_OP_REMW   = 4'd11;
  localparam logic [3:0] MD_OP_REMUW  = 4'd12;

  // Wide enough to hold the full-width iteration count of 64.
  localparam int MD_CNT_W = 7;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

  function automatic logic [63:0] md_sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic md_is_rem(input logic [3:0] op);
    return (op == MD_OP_REM) || (op == MD_OP_REMU) ||
           (op == MD_OP_REMW) || (op == MD_OP_REMUW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_md_div_iter.sv
// ---------------------------------------------------------------------------
// md_div_iter: restoring-divide datapath, one quotient bit per cycle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            abort_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  logic [XLEN-1:0]     quo_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     dsr_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [XLEN:0]       trial;
  logic [XLEN:0]       diff;
  logic                fits;

  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dsr_q};
  assign fits  = ~diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      // Word ops only iterate 32 times, so the dividend starts in the upper half.
      quo_q <= word_i ? (dividend_i << (XLEN / 2)) : dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
      cnt_q <= word_i ? MD_CNT_W'(XLEN / 2) : MD_CNT_W'(XLEN);
    end else if (cnt_q != '0) begin
      rem_q <= fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q - MD_CNT_W'(1);
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == MD_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e             state_q, state_d;
  logic [3:0]            op_q;
  logic                  word_q, spec_q, neg_q, rneg_q;
  logic [XLEN-1:0]       spec_val_q;
  logic [2*XLEN-1:0]     acc_q, mcand_q;
  logic [XLEN-1:0]       mplier_q;
  logic [MD_CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  is_mul, is_div, is_word, a_signed, b_signed;
  logic [XLEN-1:0]       a_ext, b_ext, a_mag, b_mag, spec_val;
  logic                  a_neg, b_neg, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]       div_quo, div_rem;
  logic                  div_last;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       quo_fix, rem_fix, final_val;

  always_comb begin
    is_mul   = 1'b0;
    is_div   = 1'b0;
    is_word  = 1'b0;
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      MD_OP_MUL, MD_OP_MULH: begin is_mul = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      MD_OP_MULHSU:          begin is_mul = 1'b1; a_signed = 1'b1; end
      MD_OP_MULHU:           is_mul = 1'b1;
      MD_OP_DIV, MD_OP_REM:  begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      MD_OP_DIVU, MD_OP_REMU: is_div = 1'b1;
      MD_OP_MULW: begin is_mul = 1'b1; is_word = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      MD_OP_DIVW, MD_OP_REMW: begin
        is_div = 1'b1; is_word = 1'b1; a_signed = 1'b1; b_signed = 1'b1;
      end
      MD_OP_DIVUW, MD_OP_REMUW: begin is_div = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    a_ext = rs1_data_i;
    b_ext = rs2_data_i;
    if (is_word) begin
      a_ext = a_signed ? md_sext32(rs1_data_i[31:0]) : {{(XLEN-32){1'b0}}, rs1_data_i[31:0]};
      b_ext = b_signed ? md_sext32(rs2_data_i[31:0]) : {{(XLEN-32){1'b0}}, rs2_data_i[31:0]};
    end
    a_neg = a_signed & a_ext[XLEN-1];
    b_neg = b_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & a_signed & (&b_ext) &
               (a_ext == (is_word ? md_sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
    // Undefined op codes fall into the special path with a zero result.
    special  = ~is_mul & (~is_div | div_zero | div_ovf);

    spec_val = '0;
    if (div_zero)     spec_val = md_is_rem(op_i) ? a_ext : '1;
    else if (div_ovf) spec_val = md_is_rem(op_i) ? '0 : a_ext;
    if (is_word)      spec_val = md_sext32(spec_val[31:0]);
  end

  assign accept = (state_q == MD_ST_IDLE) & start_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = MD_ST_IDLE;
    end else begin
      case (state_q)
        MD_ST_IDLE: if (start_i) state_d = special ? MD_ST_DONE : (is_mul ? MD_ST_MUL : MD_ST_DIV);
        MD_ST_MUL:  if (cnt_q == MD_CNT_W'(1)) state_d = MD_ST_DONE;
        MD_ST_DIV:  if (div_last) state_d = MD_ST_DONE;
        MD_ST_DONE: state_d = MD_ST_IDLE;
        default:    state_d = MD_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_ST_IDLE;
      op_q       <= '0;
      word_q     <= 1'b0;
      spec_q     <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_val_q <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q       <= op_i;
        word_q     <= is_word;
        spec_q     <= special;
        neg_q      <= a_neg ^ b_neg;
        rneg_q     <= a_neg;
        spec_val_q <= spec_val;
        acc_q      <= '0;
        mcand_q    <= {{XLEN{1'b0}}, a_mag};
        mplier_q   <= b_mag;
        cnt_q      <= is_word ? MD_CNT_W'(XLEN / 2) : MD_CNT_W'(XLEN);
      end else if (state_q == MD_ST_MUL) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - MD_CNT_W'(1);
      end
    end
  end

  md_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept & is_div & ~special),
    .abort_i     (flush_i),
    .word_i      (is_word),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  always_comb begin
    prod      = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -div_quo : div_quo;
    rem_fix   = rneg_q ? -div_rem : div_rem;
    final_val = '0;
    case (op_q)
      MD_OP_MUL, MD_OP_MULW:                  final_val = prod[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU:  final_val = prod[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU, MD_OP_DIVW, MD_OP_DIVUW: final_val = quo_fix;
      MD_OP_REM, MD_OP_REMU, MD_OP_REMW, MD_OP_REMUW: final_val = rem_fix;
      default: ;
    endcase
    if (spec_q) final_val = spec_val_q;
    if (word_q) final_val = md_sext32(final_val[31:0]);
    result_d = ((state_q == MD_ST_DONE) && !flush_i) ? final_val : result_q;
  end

  assign result_o = result_d;
  assign done_o   = (state_q == MD_ST_DONE) & ~flush_i;
  assign busy_o   = accept | (state_q == MD_ST_MUL) | (state_q == MD_ST_DIV);

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv: directed checks of ex_muldiv results, latency and flush. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [3:0]  op_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at cycle 0, then scramble inputs so operand capture is exercised.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int          lat;
    logic        busy_ok;
    logic        busy_done;
    logic [63:0] res;
    lat = -1; busy_ok = 1'b1; busy_done = 1'b1; res = '0;
    @(negedge clk);
    op_i = op; rs1_data_i = a; rs2_data_i = b; start_i = 1'b1;
    #1;
    chk({tag, "/busy0"}, {63'd0, busy_o}, 64'd1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_i    = 1'b0;
        op_i       = 4'($urandom_range(0, 15));
        rs1_data_i = {$urandom, $urandom};
        rs2_data_i = {$urandom, $urandom};
      end
      #1;
      if (done_o === 1'b1) begin
        lat = k; res = result_o; busy_done = busy_o;
        break;
      end
      if (busy_o !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/result"}, res, exp);
    chk({tag, "/busy_run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "/busy_done"}, {63'd0, busy_done}, 64'd0);
    @(negedge clk); #1;
    chk({tag, "/done_pulse"}, {63'd0, done_o}, 64'd0);
    chk({tag, "/hold"}, result_o, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset/busy", {63'd0, busy_o}, 64'd0);
    chk("reset/done", {63'd0, done_o}, 64'd0);
    chk("reset/result", result_o, 64'd0);
    rst = 1'b0;

    run_op("mul_neg",   4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("mulhu",     4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
    run_op("mulh",      4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("mulhsu",    4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("mulw",      4'd8, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("div_ovf",   4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",   4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divu_zero", 4'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_zero", 4'd7, 64'd7, 64'd0, 64'd7, 1);
    run_op("divw",      4'd9, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw",      4'd11, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divu",      4'd5, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu",      4'd7, 64'd100, 64'd7, 64'd2, 65);
    run_op("div_sgn",   4'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_sgn",   4'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_op("rem_negdd", 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divuw",     4'd10, 64'h1234_5678_FFFF_FFF0, 64'h9999_0000_0000_0010,
           64'h0000_0000_0FFF_FFFF, 33);
    run_op("remuw",     4'd12, 64'h0000_0000_FFFF_FFFF, 64'd16, 64'd15, 33);
    run_op("divw_ovf",  4'd9, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf",  4'd11, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
    run_op("remuw_zero", 4'd12, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("bad_op",    4'd13, 64'd9, 64'd9, 64'd0, 1);
    run_op("divu_seed", 4'd5, 64'd100, 64'd7, 64'd14, 65);

    // Flush a DIVU at cycle 10, then start a MUL at cycle 12 (done at 77).
    @(negedge clk);
    op_i = 4'd5; rs1_data_i = 64'd1000; rs2_data_i = 64'd3; start_i = 1'b1;
    #1;
    chk("flush/busy0", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush/done_c10", {63'd0, done_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush/busy_c11", {63'd0, busy_o}, 64'd0);
    chk("flush/done_c11", {63'd0, done_o}, 64'd0);
    chk("flush/result_c11", result_o, 64'd14);
    run_op("mul_after_flush", 4'd0, 64'd2, 64'd2, 64'd4, 65);

    // Flush together with start in IDLE: the op must not be accepted.
    @(negedge clk);
    op_i = 4'd0; rs1_data_i = 64'd5; rs2_data_i = 64'd5; start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("flush_start/busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_start/busy_next", {63'd0, busy_o}, 64'd0);
    chk("flush_start/done_next", {63'd0, done_o}, 64'd0);

    // Reset in the middle of a multiply: back to reset values, no done.
    @(negedge clk);
    op_i = 4'd0; rs1_data_i = 64'd5; rs2_data_i = 64'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst/busy", {63'd0, busy_o}, 64'd0);
    chk("midrst/done", {63'd0, done_o}, 64'd0);
    chk("midrst/result", result_o, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1) seen = 1'b1;
    end
    chk("midrst/no_done", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded M-extension op and the rs1/rs2 operands latched by ID/EX.
- Holds the pipeline via busy_o until the result is ready, then presents a 64-bit writeback value with a one-cycle done_o pulse.
- Radix-2 shift-add multiply and restoring divide: one iteration per cycle.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  valid M-extension op present from ID/EX this cycle
- op_i  in  4  M-op code (`MD_OP_*`)
- rs1_data_i  in  64  operand A (dividend / multiplicand)
- rs2_data_i  in  64  operand B (divisor / multiplier)
- flush_i  in  1  pipeline flush; abort any op in flight
- busy_o  out  1  stall request to hazard unit
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  64  writeback data

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high. Reset: state=IDLE, done_o=0, result_o=0, busy_o=0, all internal registers 0.
- Op codes (4 bits): MUL 0, MULH 1, MULHSU 2, MULHU 3, DIV 4, DIVU 5, REM 6, REMU 7, MULW 8, DIVW 9, DIVUW 10, REMW 11, REMUW 12. Codes 13-15 take the special path: result 0, done at cycle 1.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + start_i (and no flush_i):
  - Special divide case (divisor 0, or signed overflow) goes to DONE.
  - Multiply ops go to MUL; divide ops go to DIV.
  - Operands are captured in the start cycle; the unit ignores input changes afterwards.
- MUL/DIV: iteration counter loads N (64, or 32 for W ops), decrements each cycle, and moves to DONE when it reaches 0.
- DONE: done_o=1 for exactly one cycle, result_o valid; next state IDLE.
- result_o holds its value until the next DONE.
- busy_o is combinational: (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV. It is low in DONE so the stage advances with done_o.
- Latency, with start sampled at cycle 0:
  - done_o high at cycle N+1 (65 for full width, 33 for W ops).
  - Special cases: done_o high at cycle 1.
- Multiply:
  - 128-bit product computed over the magnitudes, with sign fixup from the operand signs.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
- Divide (restoring):
  - Operates on magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: quotient = all ones; remainder = dividend (32-bit dividend for W ops, then sign-extended).
- Signed overflow (dividend = most negative value, divisor = -1): quotient = dividend; remainder = 0. Detected at 32 bits for DIVW/REMW.
- W ops:
  - Operands are rs[31:0]: sign-extended for MULW/DIVW/REMW, zero-extended for DIVUW/REMUW.
  - Result is the 32-bit value sign-extended to 64 bits.
- flush_i:
  - In any state, next state is IDLE. done_o is forced 0 that cycle and the next; result_o is unchanged.
  - flush_i together with start_i in IDLE: flush wins and the op is not accepted.
- start_i in MUL/DIV/DONE is ignored; the hazard unit never asserts it there.
- rst mid-operation: immediate return to reset values on the next edge; no done_o.

Decomposition:
- `MD_OP_*` codes and `MD_ST_*` state encodings go in defines.v alongside the existing AluOp/AluSel definitions.
- One sub-module: md_div_iter, the restoring-divide datapath. It holds the shift register and counter and exposes quotient, remainder and last-iteration outputs.
- Multiply iteration and sign fixup stay in ex_muldiv.

Test Plan:
- MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB -> busy_o high cycles 0-64; done_o at cycle 65; result_o=0xFFFF_FFFF_FFFF_FFF1.
- MULHU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> result_o=0x1. MULH same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> done_o at cycle 1, result_o=0x8000_0000_0000_0000. REM same operands -> 0.
- DIVU rs1=7, rs2=0 -> result_o=0xFFFF_FFFF_FFFF_FFFF. REMU rs1=7, rs2=0 -> 7. Both done_o at cycle 1.
- DIVW rs1=0x1_FFFF_FFF9 (low word -7), rs2=2 -> done_o at cycle 33, result_o=0xFFFF_FFFF_FFFF_FFFD. REMW same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU started, flush_i at cycle 10 -> busy_o=0 at cycle 11, no done_o. New MUL 2*2 at cycle 12 -> done_o at cycle 77, result_o=4.
